sr_flag_arbiter: RTL and testbench



---
 rtl/sr_flag_arbiter.sv | 133 +++++++++++++
 tb/tb_sr_flag_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising per-requester set/clear commands onto a shared SR flag bank.
// Optional macro SR_TOGGLE_EN: S=1,R=1 toggles the flag (JK behaviour) and conflict is tied low.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 6,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        s_cmd,
    input  logic [NREQ-1:0]        r_cmd,
    input  logic [NREQ*IDXW-1:0]   flag_idx,
    output logic [NREQ-1:0]        gnt,
    output logic [NFLAG-1:0]       flags,
    output logic                   busy,
    output logic                   conflict,
    output logic                   idx_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_ptr_nxt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic              w_any;
    logic [NFLAG-1:0]  r_flags;
    logic [NFLAG-1:0]  w_flags_nxt;
    logic              r_idx_err;
    logic              w_idx_err_nxt;
    logic              w_sel_s;
    logic              w_sel_r;
    logic [IDXW-1:0]   w_sel_idx;
    logic              w_idx_ok;

    // A requester whose grant is showing this cycle is masked so it cannot
    // be executed twice while it is dropping req.
    always_comb begin : arb_search
        int j;
        j      = 0;
        w_elig = req & ~r_gnt;
        w_any  = 1'b0;
        w_win  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_any && w_elig[PW'(j)]) begin
                w_any = 1'b1;
                w_win = PW'(j);
            end
        end
    end

    always_comb begin : arb_decode
        w_gnt_nxt = '0;
        if (w_any) w_gnt_nxt[w_win] = 1'b1;
        w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + PW'(1);
        w_sel_s   = s_cmd[w_win];
        w_sel_r   = r_cmd[w_win];
        w_sel_idx = flag_idx[w_win*IDXW +: IDXW];
        w_idx_ok  = (int'(w_sel_idx) < NFLAG);
    end

    always_comb begin : flag_update
        w_flags_nxt   = r_flags;
        w_idx_err_nxt = w_any && !w_idx_ok;
        if (w_any && w_idx_ok) begin
            for (int n = 0; n < NFLAG; n++) begin
                if (IDXW'(n) == w_sel_idx) begin
                    case ({w_sel_s, w_sel_r})
                        2'b10:   w_flags_nxt[n] = 1'b1;
                        2'b01:   w_flags_nxt[n] = 1'b0;
`ifdef SR_TOGGLE_EN
                        2'b11:   w_flags_nxt[n] = ~r_flags[n];
`endif
                        default: w_flags_nxt[n] = r_flags[n];
                    endcase
                end
            end
        end
    end

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
            S_GRANT: w_state_nxt = w_any ? S_GRANT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_flags   <= '0;
            r_idx_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_flags   <= w_flags_nxt;
            r_idx_err <= w_idx_err_nxt;
            if (w_any) r_ptr <= w_ptr_nxt;
        end
    end

`ifdef SR_TOGGLE_EN
    assign conflict = 1'b0;
`else
    logic r_conflict;

    always_ff @(posedge clk) begin
        if (reset) r_conflict <= 1'b0;
        else       r_conflict <= w_any && w_sel_s && w_sel_r;
    end

    assign conflict = r_conflict;
`endif

    assign gnt     = r_gnt;
    assign flags   = r_flags;
    assign busy    = (r_state == S_GRANT);
    assign idx_err = r_idx_err;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: scenario tasks with an expected-result queue popped on each grant.
// Handshake: a requester holds req until it sees its own gnt bit, then drops it.
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDXW  = 3;
    localparam int W     = NREQ + NFLAG + 3;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      s_cmd;
    logic [NREQ-1:0]      r_cmd;
    logic [NREQ*IDXW-1:0] flag_idx;
    logic [NREQ-1:0]      gnt;
    logic [NFLAG-1:0]     flags;
    logic                 busy;
    logic                 conflict;
    logic                 idx_err;

    logic [W-1:0]         exp_q[$];
    logic [NFLAG-1:0]     m_flags;
    int                   n_vec;
    int                   n_err;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset), .req(req), .s_cmd(s_cmd), .r_cmd(r_cmd),
        .flag_idx(flag_idx), .gnt(gnt), .flags(flags), .busy(busy),
        .conflict(conflict), .idx_err(idx_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SR_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    function automatic logic [NFLAG-1:0] model_flags(input logic [NFLAG-1:0] f, input logic s,
                                                     input logic r, input logic [IDXW-1:0] idx);
        logic [NFLAG-1:0] o;
        o = f;
        if (int'(idx) < NFLAG) begin
            if (s && !r)      o[idx] = 1'b1;
            else if (!s && r) o[idx] = 1'b0;
            else if (s && r && TOGGLE) o[idx] = ~f[idx];
        end
        return o;
    endfunction

    // driver: one lone command from idle, checked at its grant and one cycle later
    task automatic issue(input int rq, input logic s, input logic r, input logic [IDXW-1:0] idx,
                         input logic [NFLAG-1:0] eflags, input logic econf, input logic eierr);
        logic [NREQ-1:0] g;
        logic [W-1:0]    e;
        logic [W-1:0]    a;
        int              lat;
        bit              got;
        g = 4'b0001;
        g = g << rq;
        req = '0; s_cmd = '0; r_cmd = '0;
        s_cmd[rq] = s;
        r_cmd[rq] = r;
        flag_idx[rq*IDXW +: IDXW] = idx;
        req[rq] = 1'b1;
        exp_q.push_back({g, eflags, 1'b1, econf, eierr});
        got = 1'b0;
        lat = 0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (gnt !== '0) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL grant_timeout req%0d: no gnt within %0d cycles, required %b", rq, lat, g);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            a = {gnt, flags, busy, conflict, idx_err};
            if (a !== e) begin
                n_err++;
                $display("FAIL cmd req%0d s%0b r%0b idx%0d: got gnt/flags/busy/conf/ierr %b, required %b",
                         rq, s, r, idx, a, e);
            end
            n_vec++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL latency req%0d: got %0d cycles, required 1", rq, lat);
            end
        end
        req = '0; s_cmd = '0; r_cmd = '0;
        @(negedge clk);
        n_vec++;
        if ({gnt, busy, conflict, idx_err} !== '0) begin
            n_err++;
            $display("FAIL pulse_end req%0d: got gnt/busy/conf/ierr %b, required 0",
                     rq, {gnt, busy, conflict, idx_err});
        end
        m_flags = eflags;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_flags = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '1; s_cmd = '1; r_cmd = '0; flag_idx = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if ({gnt, flags, busy, conflict, idx_err} !== '0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: got %b, required 0", c, {gnt, flags, busy, conflict, idx_err});
            end
        end
        reset = 1'b0;
        req = '0; s_cmd = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({gnt, flags, busy, conflict, idx_err} !== '0) begin
                n_err++;
                $display("FAIL idle cyc%0d: got %b, required 0", c, {gnt, flags, busy, conflict, idx_err});
            end
        end
        m_flags = '0;
    endtask

    task automatic test_set_clear();
        issue(2, 1'b1, 1'b0, 3'd3, 6'b001000, 1'b0, 1'b0);
        issue(2, 1'b0, 1'b1, 3'd3, 6'b000000, 1'b0, 1'b0);
        issue(2, 1'b0, 1'b0, 3'd3, 6'b000000, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] e;
        logic [W-1:0] a;
        int busy_cnt;
        int first_c;
        int last_c;
        pulse_reset();
        req = '1; s_cmd = '1; r_cmd = '0;
        flag_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        exp_q.push_back({4'b0001, 6'b000001, 3'b100});
        exp_q.push_back({4'b0010, 6'b000011, 3'b100});
        exp_q.push_back({4'b0100, 6'b000111, 3'b100});
        exp_q.push_back({4'b1000, 6'b001111, 3'b100});
        busy_cnt = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (gnt !== '0) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                a = {gnt, flags, busy, conflict, idx_err};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rr_extra cyc%0d: got %b, required no grant", c, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL rr_grant cyc%0d: got %b, required %b", c, a, e);
                    end
                end
                req = req & ~gnt;
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rr_missing: got %0d grants outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        n_vec++;
        if (busy_cnt != 4) begin
            n_err++;
            $display("FAIL rr_busy: got %0d busy cycles, required 4", busy_cnt);
        end
        n_vec++;
        if (last_c - first_c != 3) begin
            n_err++;
            $display("FAIL rr_consecutive: got span %0d, required 3", last_c - first_c);
        end
        req = '0; s_cmd = '0;
        m_flags = 6'b001111;
    endtask

    task automatic test_conflict();
        if (TOGGLE) issue(0, 1'b1, 1'b1, 3'd1, 6'b001101, 1'b0, 1'b0);
        else        issue(0, 1'b1, 1'b1, 3'd1, 6'b001111, 1'b1, 1'b0);
    endtask

    task automatic test_out_of_range();
        issue(1, 1'b1, 1'b0, 3'd7, m_flags, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [NFLAG-1:0] pre;
        pre = m_flags;
        @(negedge clk);
        req = '1; s_cmd = '1; r_cmd = '0;
        flag_idx = {4{3'd4}};
        @(negedge clk);
        n_vec++;
        if ({gnt, busy, flags} !== {4'b0100, 1'b1, pre | 6'b010000}) begin
            n_err++;
            $display("FAIL mid_pre_grant: got gnt/busy/flags %b, required %b",
                     {gnt, busy, flags}, {4'b0100, 1'b1, pre | 6'b010000});
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({gnt, flags, busy, conflict, idx_err} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got %b, required 0", {gnt, flags, busy, conflict, idx_err});
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({gnt, flags} !== {4'b0001, 6'b010000}) begin
            n_err++;
            $display("FAIL mid_first_after_reset: got gnt/flags %b, required %b",
                     {gnt, flags}, {4'b0001, 6'b010000});
        end
        req = '0; s_cmd = '0;
        @(negedge clk);
        @(negedge clk);
        m_flags = 6'b010000;
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0]  eg;
        logic             s;
        logic             r;
        logic [IDXW-1:0]  idx;
        logic [NFLAG-1:0] ef;
        int               rq;
        req = 4'b1000; s_cmd = '0; r_cmd = '0; flag_idx = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            eg = (c % 2 == 0) ? 4'b1000 : 4'b0000;
            n_vec++;
            if ({gnt, flags} !== {eg, m_flags}) begin
                n_err++;
                $display("FAIL lone_hold cyc%0d: got gnt/flags %b, required %b", c, {gnt, flags}, {eg, m_flags});
            end
        end
        req = '0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rq  = $urandom_range(0, NREQ - 1);
            s   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            idx = IDXW'($urandom_range(0, 7));
            ef  = model_flags(m_flags, s, r, idx);
            issue(rq, s, r, idx, ef, s && r && !TOGGLE, int'(idx) >= NFLAG);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_flags = '0;
        reset = 1'b1;
        req = '0; s_cmd = '0; r_cmd = '0; flag_idx = '0;
        test_reset();
        test_set_clear();
        test_round_robin();
        test_conflict();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
